// File: rtl/msftdvip_clint_apb_bridge.sv
// APB slave front-end for the CLINT timer register port: window decode, one register
// access per transfer, and a bounded wait for the register port's ready.
module msftdvip_clint_apb_bridge #(
  parameter logic [31:0] BASE_ADDR = 32'h0200_0000,
  parameter int unsigned TIMEOUT   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        psel_i,
  input  logic        penable_i,
  input  logic [31:0] paddr_i,
  input  logic        pwrite_i,
  input  logic [31:0] pwdata_i,
  input  logic [3:0]  pstrb_i,
  output logic [31:0] prdata_o,
  output logic        pready_o,
  output logic        pslverr_o,
  output logic        reg_en_o,
  output logic [31:0] reg_addr_o,
  output logic [31:0] reg_wdata_o,
  output logic        reg_we_o,
  input  logic [31:0] reg_rdata_i,
  input  logic        reg_ready_i
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUE  = 2'd1,
    S_RDWAIT = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [7:0]  r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_write;
  logic        r_err;
  logic [7:0]  r_cnt;

  logic w_setup;
  logic w_bad;
  logic w_issue;
  logic w_resp;

  assign w_setup = psel_i & ~penable_i;
  assign w_bad   = (paddr_i[31:8] != BASE_ADDR[31:8])
                 | (paddr_i[1:0] != 2'b00)
                 | (pwrite_i & (pstrb_i != 4'hF));

  // A decode error also spends one cycle in ISSUE, with the register port masked,
  // so that error responses land at T+2 like a zero-wait write.
  assign w_issue = (r_state == S_ISSUE) & ~r_err;
  assign w_resp  = (r_state == S_RESP);

  always_comb begin
    // NOTE: w_next gets a default before the case so every path assigns it and no latch is inferred.
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_setup) w_next = S_ISSUE;
      end
      S_ISSUE: begin
        if (!psel_i)                   w_next = S_IDLE;
        else if (r_err)                w_next = S_RESP;
        else if (reg_ready_i)          w_next = r_write ? S_RESP : S_RDWAIT;
        else if (r_cnt == LP_LAST_WAIT) w_next = S_RESP;
      end
      S_RDWAIT: begin
        w_next = psel_i ? S_RESP : S_IDLE;
      end
      S_RESP: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    // NOTE: every sequential assignment is non-blocking so all registers update from pre-edge values.
    if (rst_i) begin
      r_state <= S_IDLE;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_write <= 1'b0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_setup) begin
            r_addr  <= paddr_i[7:0];
            r_wdata <= pwdata_i;
            r_write <= pwrite_i;
            r_err   <= w_bad;
            r_cnt   <= '0;
          end
        end
        S_ISSUE: begin
          if (psel_i && !r_err && !reg_ready_i) begin
            if (r_cnt == LP_LAST_WAIT) r_err <= 1'b1;
            else                       r_cnt <= r_cnt + 8'd1;
          end
        end
        S_RDWAIT: begin
          r_rdata <= reg_rdata_i;
        end
        default: begin
        end
      endcase
    end
  end

  assign reg_en_o    = w_issue;
  assign reg_addr_o  = {24'h0, r_addr};
  assign reg_wdata_o = w_issue ? r_wdata : '0;
  assign reg_we_o    = w_issue & r_write;

  assign pready_o  = w_resp;
  assign pslverr_o = w_resp & r_err;
  assign prdata_o  = (w_resp && !r_err && !r_write) ? r_rdata : '0;

endmodule
